// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file: address-width helper
// and the index of the optional hard-wired zero register.
package regfile_sb_pkg;

    localparam int ZERO_REG = 0;

    // Address width for n registers; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_cell.sv
// One WIDTH-bit storage register with synchronous active-low clear and load enable.
module regfile_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with optional write-to-read bypass, optional zero
// register and a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int NREGS   = 8,
    parameter  int BYPASS  = 1,
    parameter  int ZERO_R0 = 0,
    localparam int AW      = addr_w(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] buss,
    input  logic [AW-1:0]    dr,
    input  logic             reg_we,
    input  logic [AW-1:0]    sr1,
    input  logic [AW-1:0]    sr2,
    input  logic             use_sr1,
    input  logic             use_sr2,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_dr,
    output logic [WIDTH-1:0] ra,
    output logic [WIDTH-1:0] rb,
    output logic             stall,
    output logic             issue_ack,
    output logic [NREGS-1:0] busy
);

    localparam logic [AW-1:0] ZADDR = AW'(ZERO_REG);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] eb;
    logic [NREGS-1:0] busy_nxt;

    for (genvar i = 0; i < NREGS; i++) begin : g_cell
        logic load;
        // The zero register never loads, so it stays at its reset value.
        assign load = reg_we && (dr == AW'(i)) && !((ZERO_R0 != 0) && (i == ZERO_REG));

        regfile_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .d     (buss),
            .q     (regs[i])
        );
    end

    always_comb begin
        ra = regs[sr1];
        if ((BYPASS != 0) && reg_we && (dr == sr1)) begin
            ra = buss;
        end
        if ((ZERO_R0 != 0) && (sr1 == ZADDR)) begin
            ra = '0;
        end

        rb = regs[sr2];
        if ((BYPASS != 0) && reg_we && (dr == sr2)) begin
            rb = buss;
        end
        if ((ZERO_R0 != 0) && (sr2 == ZADDR)) begin
            rb = '0;
        end
    end

    // A writeback landing this cycle only resolves the hazard when it is forwarded.
    always_comb begin
        eb = busy;
        for (int i = 0; i < NREGS; i++) begin
            if ((BYPASS != 0) && reg_we && (dr == AW'(i))) begin
                eb[i] = 1'b0;
            end
        end
    end

    always_comb begin
        stall = issue_valid &&
                ((use_sr1 && eb[sr1]) || (use_sr2 && eb[sr2]) || eb[issue_dr]);
        issue_ack = issue_valid && !stall;
    end

    // Set after clear so a new producer issued on the writeback edge stays outstanding.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NREGS; i++) begin
            if (reg_we && (dr == AW'(i))) begin
                busy_nxt[i] = 1'b0;
            end
            if (issue_ack && (issue_dr == AW'(i)) &&
                !((ZERO_R0 != 0) && (i == ZERO_REG))) begin
                busy_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: vector table on the default build, hand sequences for the
// no-bypass, zero-register and 32x16 builds.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic [15:0] buss;
    logic [2:0]  dr, sr1, sr2, issue_dr;
    logic        reg_we, use_sr1, use_sr2, issue_valid;

    logic [15:0] d_ra, d_rb, nb_ra, nb_rb, z_ra, z_rb;
    logic        d_stall, d_ack, nb_stall, nb_ack, z_stall, z_ack;
    logic [7:0]  d_busy, nb_busy, z_busy;

    logic        w_reset;
    logic [31:0] w_buss, w_ra, w_rb;
    logic [3:0]  w_dr, w_sr1, w_sr2, w_issue_dr;
    logic        w_we, w_use1, w_use2, w_iv, w_stall, w_ack;
    logic [15:0] w_busy;

    int n_chk = 0;
    int n_pass = 0;

    regfile_sb u_dut (
        .clk(clk), .reset(reset), .buss(buss), .dr(dr), .reg_we(reg_we),
        .sr1(sr1), .sr2(sr2), .use_sr1(use_sr1), .use_sr2(use_sr2),
        .issue_valid(issue_valid), .issue_dr(issue_dr),
        .ra(d_ra), .rb(d_rb), .stall(d_stall), .issue_ack(d_ack), .busy(d_busy)
    );

    regfile_sb #(.BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .buss(buss), .dr(dr), .reg_we(reg_we),
        .sr1(sr1), .sr2(sr2), .use_sr1(use_sr1), .use_sr2(use_sr2),
        .issue_valid(issue_valid), .issue_dr(issue_dr),
        .ra(nb_ra), .rb(nb_rb), .stall(nb_stall), .issue_ack(nb_ack), .busy(nb_busy)
    );

    regfile_sb #(.ZERO_R0(1)) u_z (
        .clk(clk), .reset(reset), .buss(buss), .dr(dr), .reg_we(reg_we),
        .sr1(sr1), .sr2(sr2), .use_sr1(use_sr1), .use_sr2(use_sr2),
        .issue_valid(issue_valid), .issue_dr(issue_dr),
        .ra(z_ra), .rb(z_rb), .stall(z_stall), .issue_ack(z_ack), .busy(z_busy)
    );

    regfile_sb #(.WIDTH(32), .NREGS(16)) u_w (
        .clk(clk), .reset(w_reset), .buss(w_buss), .dr(w_dr), .reg_we(w_we),
        .sr1(w_sr1), .sr2(w_sr2), .use_sr1(w_use1), .use_sr2(w_use2),
        .issue_valid(w_iv), .issue_dr(w_issue_dr),
        .ra(w_ra), .rb(w_rb), .stall(w_stall), .issue_ack(w_ack), .busy(w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, we;
        logic [2:0]  dr;
        logic [15:0] bus;
        logic [2:0]  s1, s2;
        logic        u1, u2, iv;
        logic [2:0]  idr;
        logic        cc;
        logic [15:0] era, erb;
        logic        est, eack;
        logic [7:0]  ebusy;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic we, input logic [2:0] d, input logic [15:0] bus,
        input logic [2:0] s1, input logic [2:0] s2, input logic u1, input logic u2,
        input logic iv, input logic [2:0] idr, input logic cc,
        input logic [15:0] era, input logic [15:0] erb, input logic est,
        input logic eack, input logic [7:0] ebusy);
        vec_t v;
        v.rst = rst; v.we = we; v.dr = d; v.bus = bus; v.s1 = s1; v.s2 = s2;
        v.u1 = u1; v.u2 = u2; v.iv = iv; v.idr = idr; v.cc = cc;
        v.era = era; v.erb = erb; v.est = est; v.eack = eack; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic rst, input logic we, input logic [2:0] d,
                         input logic [15:0] bus, input logic [2:0] s1, input logic [2:0] s2,
                         input logic u1, input logic u2, input logic iv, input logic [2:0] idr);
        reset = rst; reg_we = we; dr = d; buss = bus; sr1 = s1; sr2 = s2;
        use_sr1 = u1; use_sr2 = u2; issue_valid = iv; issue_dr = idr;
    endtask

    vec_t vecs[18];

    initial begin
        //              rst we dr bus      s1 s2 u1 u2 iv idr cc ra       rb       st ack busy
        vecs[0]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00);
        vecs[1]  = mk(1, 0, 0, 16'h0000, 3, 7, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 8'h00);
        vecs[2]  = mk(1, 1, 5, 16'hBEEF, 5, 3, 0, 0, 0, 0, 1, 16'hBEEF, 16'h0000, 0, 0, 8'h00);
        vecs[3]  = mk(1, 0, 0, 16'h0000, 5, 5, 0, 0, 0, 0, 1, 16'hBEEF, 16'hBEEF, 0, 0, 8'h00);
        vecs[4]  = mk(1, 0, 0, 16'h0000, 5, 5, 0, 0, 1, 2, 1, 16'hBEEF, 16'hBEEF, 0, 1, 8'h04);
        vecs[5]  = mk(1, 0, 0, 16'h0000, 2, 5, 1, 0, 1, 1, 1, 16'h0000, 16'hBEEF, 1, 0, 8'h04);
        vecs[6]  = mk(1, 1, 2, 16'h1234, 2, 5, 1, 0, 1, 1, 1, 16'h1234, 16'hBEEF, 0, 1, 8'h02);
        vecs[7]  = mk(1, 0, 0, 16'h0000, 2, 5, 0, 0, 1, 4, 1, 16'h1234, 16'hBEEF, 0, 1, 8'h12);
        vecs[8]  = mk(1, 0, 0, 16'h0000, 2, 5, 0, 0, 1, 4, 1, 16'h1234, 16'hBEEF, 1, 0, 8'h12);
        vecs[9]  = mk(1, 1, 6, 16'h0606, 6, 5, 0, 0, 1, 6, 1, 16'h0606, 16'hBEEF, 0, 1, 8'h52);
        vecs[10] = mk(1, 0, 0, 16'h0000, 5, 6, 0, 1, 1, 7, 1, 16'hBEEF, 16'h0606, 1, 0, 8'h52);
        vecs[11] = mk(1, 0, 0, 16'h0000, 5, 6, 0, 0, 1, 7, 1, 16'hBEEF, 16'h0606, 0, 1, 8'hD2);
        vecs[12] = mk(1, 1, 1, 16'h1111, 1, 4, 1, 0, 0, 0, 1, 16'h1111, 16'h0000, 0, 0, 8'hD0);
        vecs[13] = mk(1, 1, 4, 16'h4444, 0, 0, 0, 0, 1, 2, 1, 16'h0000, 16'h0000, 0, 1, 8'hC4);
        vecs[14] = mk(1, 1, 6, 16'h6666, 0, 0, 0, 0, 1, 3, 1, 16'h0000, 16'h0000, 0, 1, 8'h8C);
        vecs[15] = mk(1, 1, 7, 16'h7777, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 8'h0C);
        vecs[16] = mk(0, 1, 3, 16'hAAAA, 0, 0, 0, 0, 1, 5, 0, 16'h0000, 16'h0000, 0, 0, 8'h00);
        vecs[17] = mk(1, 0, 0, 16'h0000, 3, 5, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 8'h00);

        drive(0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
        w_reset = 0; w_we = 0; w_dr = 0; w_buss = 0; w_sr1 = 0; w_sr2 = 0;
        w_use1 = 0; w_use2 = 0; w_iv = 0; w_issue_dr = 0;

        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].we, vecs[k].dr, vecs[k].bus, vecs[k].s1, vecs[k].s2,
                  vecs[k].u1, vecs[k].u2, vecs[k].iv, vecs[k].idr);
            #1;
            if (vecs[k].cc) begin
                chk($sformatf("v%0d_ra", k), 32'(d_ra), 32'(vecs[k].era));
                chk($sformatf("v%0d_rb", k), 32'(d_rb), 32'(vecs[k].erb));
                chk($sformatf("v%0d_stall", k), 32'(d_stall), 32'(vecs[k].est));
                chk($sformatf("v%0d_ack", k), 32'(d_ack), 32'(vecs[k].eack));
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_busy", k), 32'(d_busy), 32'(vecs[k].ebusy));
        end

        // No-bypass build: same-cycle write is invisible and does not unblock.
        @(negedge clk);
        drive(1, 1, 5, 16'hBEEF, 5, 0, 0, 0, 0, 0);
        #1;
        chk("nb_old_read", 32'(nb_ra), 32'h0000);
        chk("byp_new_read", 32'(d_ra), 32'hBEEF);
        @(negedge clk);
        drive(1, 0, 0, 16'h0, 5, 0, 0, 0, 1, 2);
        #1;
        chk("nb_stored_read", 32'(nb_ra), 32'hBEEF);
        chk("nb_issue_ack", 32'(nb_ack), 32'h1);
        @(posedge clk); #1;
        chk("nb_busy_set", 32'(nb_busy), 32'h04);
        @(negedge clk);
        drive(1, 1, 2, 16'h1234, 2, 0, 1, 0, 1, 1);
        #1;
        chk("nb_raw_stall", 32'(nb_stall), 32'h1);
        chk("nb_raw_ra", 32'(nb_ra), 32'h0000);
        chk("byp_raw_nostall", 32'(d_stall), 32'h0);
        chk("byp_raw_ra", 32'(d_ra), 32'h1234);
        @(posedge clk); #1;
        chk("nb_busy_clr", 32'(nb_busy), 32'h00);
        @(negedge clk);
        drive(1, 0, 0, 16'h0, 2, 0, 1, 0, 1, 1);
        #1;
        chk("nb_retry_stall", 32'(nb_stall), 32'h0);
        chk("nb_retry_ra", 32'(nb_ra), 32'h1234);
        chk("nb_retry_ack", 32'(nb_ack), 32'h1);

        // Zero-register build.
        @(negedge clk);
        drive(0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0);
        #1;
        chk("z_wr_cycle_ra", 32'(z_ra), 32'h0000);
        chk("d_r0_bypass", 32'(d_ra), 32'hFFFF);
        @(negedge clk);
        drive(1, 0, 0, 16'h0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("z_r0_read", 32'(z_ra), 32'h0000);
        chk("z_r0_readb", 32'(z_rb), 32'h0000);
        chk("d_r0_stored", 32'(d_ra), 32'hFFFF);
        chk("z_issue0_stall", 32'(z_stall), 32'h0);
        chk("z_issue0_ack", 32'(z_ack), 32'h1);
        @(posedge clk); #1;
        chk("z_busy_none", 32'(z_busy), 32'h00);
        chk("d_busy_r0", 32'(d_busy), 32'h01);
        @(negedge clk);
        #1;
        chk("z_reissue0", 32'(z_stall), 32'h0);
        chk("d_waw_r0", 32'(d_stall), 32'h1);
        @(negedge clk);
        drive(1, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0);

        // 32-bit x 16 build.
        w_reset = 1; w_we = 1; w_dr = 15; w_buss = 32'hDEADBEEF; w_sr1 = 15;
        w_iv = 1; w_issue_dr = 15;
        #1;
        chk("w_bypass_ra", w_ra, 32'hDEADBEEF);
        chk("w_ack", 32'(w_ack), 32'h1);
        @(posedge clk); #1;
        chk("w_busy_setwins", 32'(w_busy), 32'h8000);
        @(negedge clk);
        w_we = 0; w_buss = 0; w_sr1 = 15; w_sr2 = 14; w_use1 = 1; w_issue_dr = 3;
        #1;
        chk("w_r15_read", w_ra, 32'hDEADBEEF);
        chk("w_r14_read", w_rb, 32'h00000000);
        chk("w_raw_stall", 32'(w_stall), 32'h1);
        @(posedge clk); #1;
        chk("w_busy_hold", 32'(w_busy), 32'h8000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
